// File: rtl/dm_store_buffer.sv
// Store queue between MEM and data memory: sw pushes an entry, the head drains via MemWE/MemReady,
// lw reads forward from the youngest matching entry. An accepted store is visible the next cycle; Stall is asserted while the queue is full.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     DMWE,
    input  logic                     LdReq,
    input  logic [31:0]              ALUOut,
    input  logic [31:0]              DMWD,
    output logic                     Stall,
    output logic                     FwdHit,
    output logic [31:0]              FwdData,
    output logic                     MemWE,
    output logic [31:0]              MemAddr,
    output logic [31:0]              MemWD,
    input  logic                     MemReady,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] rd;
    logic [PW-1:0] wr;
    logic [CW-1:0] cnt;

    logic full;
    logic push;
    logic pop;

    // Word-aligned addressing: the byte offset plays no part in matching.
    logic unused_byte_offset;
    assign unused_byte_offset = ^ALUOut[1:0];

    assign full  = (cnt == CW'(DEPTH));
    assign Empty = (cnt == '0);
    assign Count = cnt;

    // Stall is driven from registered occupancy only, so a same-cycle pop never frees the slot.
    assign push  = DMWE && !full;
    assign Stall = DMWE && full;

    assign MemWE   = !Empty;
    assign pop     = MemWE && MemReady;
    assign MemAddr = {addr_q[rd], 2'b00};
    assign MemWD   = data_q[rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wr <= wr + 1'b1;
            end
            if (pop) begin
                rd <= rd + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset: validity is defined purely by rd/wr/cnt.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_q[wr] <= ALUOut[31:2];
            data_q[wr] <= DMWD;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest store.
    logic          match_any;
    logic [31:0]   match_data;
    logic [PW-1:0] idx;

    always_comb begin
        match_any  = 1'b0;
        match_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd + PW'(i);
            if ((CW'(i) < cnt) && (addr_q[idx] == ALUOut[31:2])) begin
                match_any  = 1'b1;
                match_data = data_q[idx];
            end
        end
    end

    assign FwdHit  = LdReq && match_any;
    assign FwdData = FwdHit ? match_data : 32'h0;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboarded bench for dm_store_buffer: a queue model tracks accepted stores, checks drain order,
// occupancy, stall and load forwarding every cycle, alongside directed scenario checks.
module tb_dm_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        DMWE;
    logic        LdReq;
    logic [31:0] ALUOut;
    logic [31:0] DMWD;
    logic        Stall;
    logic        FwdHit;
    logic [31:0] FwdData;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic        MemReady;
    logic        Empty;
    logic [$clog2(DEPTH):0] Count;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .DMWE     (DMWE),
        .LdReq    (LdReq),
        .ALUOut   (ALUOut),
        .DMWD     (DMWD),
        .Stall    (Stall),
        .FwdHit   (FwdHit),
        .FwdData  (FwdData),
        .MemWE    (MemWE),
        .MemAddr  (MemAddr),
        .MemWD    (MemWD),
        .MemReady (MemReady),
        .Empty    (Empty),
        .Count    (Count)
    );

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference forwarding: scan the model queue from youngest to oldest.
    function automatic void model_fwd(input logic [31:0] addr, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = 32'h0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].a == addr[31:2]) begin
                hit  = 1'b1;
                data = sb[i].d;
                break;
            end
        end
    endfunction

    ent_t        pop_e;
    logic        m_hit;
    logic [31:0] m_data;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            check_eq("count", 32'(Count), 32'(sb.size()));
            check_eq("empty", 32'(Empty), 32'(sb.size() == 0));
            check_eq("memwe", 32'(MemWE), 32'(sb.size() != 0));
            check_eq("stall", 32'(Stall), 32'(DMWE && (sb.size() == DEPTH)));
            if (LdReq) begin
                model_fwd(ALUOut, m_hit, m_data);
                check_eq("fwd_hit", 32'(FwdHit), 32'(m_hit));
                check_eq("fwd_data", FwdData, m_data);
            end
            if (MemWE && MemReady && sb.size() > 0) begin
                pop_e = sb.pop_front();
                check_eq("mem_addr", MemAddr, {pop_e.a, 2'b00});
                check_eq("mem_wd", MemWD, pop_e.d);
            end
            if (DMWE && !Stall) begin
                sb.push_back({ALUOut[31:2], DMWD});
            end
        end
    end

    task automatic drain();
        MemReady = 1'b1;
        DMWE     = 1'b0;
        LdReq    = 1'b0;
        for (int k = 0; k < 40 && Empty !== 1'b1; k++) tick();
        check_eq("drain_done", 32'(Empty), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        DMWE     = 1'b0;
        LdReq    = 1'b0;
        ALUOut   = '0;
        DMWD     = '0;
        MemReady = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_empty", 32'(Empty), 32'd1);
        check_eq("rst_count", 32'(Count), 32'd0);
        check_eq("rst_memwe", 32'(MemWE), 32'd0);
        check_eq("rst_stall", 32'(Stall), 32'd0);
        LdReq  = 1'b1;
        ALUOut = 32'h0;
        #1;
        check_eq("rst_fwdhit", 32'(FwdHit), 32'd0);
        check_eq("rst_fwddata", FwdData, 32'd0);
        LdReq = 1'b0;
        tick();

        // Single store with memory ready
        DMWE = 1'b1; ALUOut = 32'h100; DMWD = 32'hDEADBEEF; MemReady = 1'b1;
        tick();
        DMWE = 1'b0;
        #1;
        check_eq("single_memwe", 32'(MemWE), 32'd1);
        check_eq("single_addr", MemAddr, 32'h100);
        check_eq("single_wd", MemWD, 32'hDEADBEEF);
        tick();
        check_eq("single_empty", 32'(Empty), 32'd1);

        // Fill to DEPTH, stall, then drain in order
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            DMWE = 1'b1; ALUOut = 32'(i * 4); DMWD = 32'hA0 + 32'(i);
            tick();
        end
        ALUOut = 32'h10; DMWD = 32'hA4;
        #1;
        check_eq("fill_count", 32'(Count), 32'd4);
        check_eq("fill_stall", 32'(Stall), 32'd1);
        tick();
        MemReady = 1'b1;
        #1;
        check_eq("pop_stall_held", 32'(Stall), 32'd1);
        check_eq("pop_head0", MemAddr, 32'h0);
        tick();
        check_eq("after_pop_stall", 32'(Stall), 32'd0);
        check_eq("after_pop_head", MemAddr, 32'h4);
        check_eq("after_pop_count", 32'(Count), 32'd3);
        tick();
        DMWE = 1'b0;
        #1;
        check_eq("fifth_accepted", 32'(Count), 32'd3);
        drain();

        // Forward from the youngest of two same-address stores
        MemReady = 1'b0;
        DMWE = 1'b1; ALUOut = 32'h20; DMWD = 32'h11111111;
        tick();
        DMWD = 32'h22222222;
        tick();
        DMWE = 1'b0; LdReq = 1'b1; ALUOut = 32'h22;
        #1;
        check_eq("fwd_young_hit", 32'(FwdHit), 32'd1);
        check_eq("fwd_young_data", FwdData, 32'h22222222);
        ALUOut = 32'h24;
        #1;
        check_eq("fwd_miss_hit", 32'(FwdHit), 32'd0);
        check_eq("fwd_miss_data", FwdData, 32'h0);
        ALUOut = 32'h20; MemReady = 1'b1;
        tick();
        tick();
        drain();

        // Back-to-back push/pop across pointer wrap
        MemReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            DMWE = 1'b1; ALUOut = 32'h200 + 32'(4 * i); DMWD = $urandom;
            #1;
            if (i > 0) begin
                check_eq("pp_count", 32'(Count), 32'd1);
                check_eq("pp_addr", MemAddr, 32'h200 + 32'(4 * (i - 1)));
            end
            tick();
        end
        drain();

        // Random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            int r;
            r        = $urandom_range(0, 9);
            DMWE     = (r < 4);
            LdReq    = (r >= 4 && r < 7);
            ALUOut   = 32'h400 + 32'($urandom_range(0, 31));
            DMWD     = $urandom;
            MemReady = ($urandom_range(0, 99) < ((c < 300) ? 30 : 70));
            rst      = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        // Reset while stores are pending
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            DMWE = 1'b1; ALUOut = 32'h300 + 32'(4 * i); DMWD = 32'hC0 + 32'(i);
            tick();
        end
        DMWE = 1'b0; rst = 1'b1; MemReady = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rstmid_memwe", 32'(MemWE), 32'd0);
        check_eq("rstmid_count", 32'(Count), 32'd0);
        LdReq = 1'b1; ALUOut = 32'h304;
        #1;
        check_eq("rstmid_fwdhit", 32'(FwdHit), 32'd0);
        tick();
        LdReq = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
